mealy_ctx_arbiter: RTL and testbench
====================================

MEALY_CTX_ARBITER -- requirements
Module: mealy_ctx_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 8, max symbols per grant before forced release (range 1..255).
REQ-002 clk  in  1  clock; all state updates SHALL occur on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 a_valid  in  1  requester A offers a symbol.
REQ-005 a_sym  in  2  requester A symbol.
REQ-006 a_last  in  1  A symbol ends its packet.
REQ-007 a_ready  out  1  A symbol accepted when a_valid&&a_ready.
REQ-008 b_valid, b_sym, b_last, b_ready  same as REQ-004..007 for requester B.
REQ-009 y_valid  out  1  y/y_id valid this cycle.
REQ-010 y  out  1  Mealy output for the accepted symbol.
REQ-011 y_id  out  1  requester of the symbol (0=A, 1=B).
REQ-012 busy  out  1  high while in GRANT.

Function
REQ-013 Two-state arbiter: IDLE and GRANT; gnt register (0=A, 1=B); round-robin pointer rr (requester preferred on a tie).
REQ-014 In IDLE, if exactly one valid: gnt SHALL be set to it; if both valid: gnt=rr; if none: stay IDLE; any grant enters GRANT next cycle.
REQ-015 Only the granted requester's ready SHALL be high, and only in GRANT; both readys SHALL be low in IDLE.
REQ-016 Grant is held across multiple symbols; a granted requester dropping valid SHALL NOT release the grant.
REQ-017 Release SHALL occur on acceptance of a symbol with last=1, or of the MAX_BURST-th symbol of the grant; next state IDLE, rr set to the other requester.
REQ-018 A burst counter (8 bits) SHALL clear on grant and increment per accepted symbol.
REQ-019 Each accepted symbol SHALL advance a 2-bit working FSM state using this table (next state for x=11/10/01/00; y).
REQ-020 S0: S0/S2/S1/S0; y=0 for all x.
REQ-021 S1: S1/S3/S0/S2; y=0 for all x.
REQ-022 S2: S2/S1/S0/S3; y=1 only for x=00.
REQ-023 S3: S0/S3/S0/S1; y=1 only for x=00 or x=10.
REQ-024 y SHALL use the pre-transition state and the accepted symbol; y, y_id, y_valid SHALL be registered, so they appear exactly 1 cycle after acceptance.
REQ-025 y_valid SHALL be low in every cycle not following an acceptance.
REQ-026 Throughput: one symbol per cycle while granted; 1 idle (arbitration) cycle between grants.
REQ-027 A symbol offered by a non-granted requester SHALL be held off (ready=0) and SHALL NOT affect any state.

Reset
REQ-028 rst_n low at a clock edge SHALL force: IDLE, gnt=0, rr=0 (A), counter=0, all contexts/working state=S0, y_valid=0, y=0, y_id=0.
REQ-029 A reset mid-grant SHALL discard the grant; the symbol presented in the reset cycle SHALL NOT be accepted (ready=0 during reset).

Configuration
REQ-030 Macro MEALY_CTX_SAVE_EN defined: one saved context per requester; working state SHALL load that requester's context on grant, and the context SHALL be written back on every accepted symbol.
REQ-031 Macro undefined: no saved contexts; working state SHALL be reset to S0 on every grant, including after a MAX_BURST truncation.

Verification
REQ-032 Reset, then A sends 01,00,00(last) -> y=0,0,1 with y_id=0, each 1 cycle after acceptance; busy drops after the third symbol.
REQ-033 With MEALY_CTX_SAVE_EN defined, after REQ-032 A sends 10(last) -> y=1 (context S3); with it undefined -> y=0 (from S0).
REQ-034 A and B both valid in IDLE after reset -> A granted first; on A's last, B is granted after one idle cycle; the next tie goes to A.
REQ-035 MAX_BURST=8, B sends 10 symbols of 11 with last only on the 10th -> release after the 8th; B regranted, remaining 2 accepted; y=0 throughout.
REQ-036 rst_n low mid-grant of A (after 2 of 4 symbols) -> next cycle IDLE, y_valid=0, busy=0, contexts S0; a fresh A packet 10 -> y=0.

Source files
------------

// File: rtl/mealy_ctx_arbiter_if.sv
// Bundle of signals between the two requesters, the Mealy output port and mealy_ctx_arbiter.
// The arbiter connects through the slave modport and the requesters/observer through master.
interface mealy_ctx_arbiter_if;
    // Handshake: a symbol transfers on a rising clk edge where x_valid && x_ready are both high.
    // A requester may raise or drop valid at any time. A dropped valid never ends a grant.
    // y_valid is a one-cycle strobe with no backpressure.
    logic       a_valid;
    logic [1:0] a_sym;
    logic       a_last;
    logic       a_ready;
    logic       b_valid;
    logic [1:0] b_sym;
    logic       b_last;
    logic       b_ready;
    logic       y_valid;
    logic       y;
    logic       y_id;
    logic       busy;
    logic       dbg_state;
    logic [1:0] dbg_work;

    modport master (
        output a_valid, a_sym, a_last, b_valid, b_sym, b_last,
        input  a_ready, b_ready, y_valid, y, y_id, busy, dbg_state, dbg_work
    );

    modport slave (
        input  a_valid, a_sym, a_last, b_valid, b_sym, b_last,
        output a_ready, b_ready, y_valid, y, y_id, busy, dbg_state, dbg_work
    );
endinterface

// File: rtl/mealy_ctx_arbiter.sv
// Two-requester round-robin burst arbiter feeding a 2-bit Mealy machine with a registered output.
// Define MEALY_CTX_SAVE_EN to keep a saved Mealy context per requester across grants.
module mealy_ctx_arbiter #(
    parameter int MAX_BURST = 8
) (
    input logic                clk,
    input logic                rst_n,
    mealy_ctx_arbiter_if.slave bus
);

    typedef enum logic { IDLE = 1'b0, GRANT = 1'b1 } arb_state_t;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t state;
    logic       gnt;
    logic       rr;
    logic [7:0] burst_cnt;
    logic [1:0] work;
    logic       y_valid_q;
    logic       y_q;
    logic       y_id_q;

`ifdef MEALY_CTX_SAVE_EN
    logic [1:0] ctx_a;
    logic [1:0] ctx_b;
`endif

    logic       acc;
    logic [1:0] acc_sym;
    logic       acc_last;
    logic       release_now;
    logic       win;
    logic [1:0] work_nxt;
    logic       y_nxt;
    logic [1:0] grant_load;

    // Ready is gated by rst_n so a symbol offered during a reset cycle is never taken.
    assign bus.a_ready = rst_n && (state == GRANT) && !gnt;
    assign bus.b_ready = rst_n && (state == GRANT) && gnt;

    assign acc         = (bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready);
    assign acc_sym     = gnt ? bus.b_sym  : bus.a_sym;
    assign acc_last    = gnt ? bus.b_last : bus.a_last;
    assign release_now = acc && (acc_last || (burst_cnt == BURST_LAST));
    assign win         = (bus.a_valid && bus.b_valid) ? rr : bus.b_valid;

`ifdef MEALY_CTX_SAVE_EN
    assign grant_load = win ? ctx_b : ctx_a;
`else
    assign grant_load = S0;
`endif

    always_comb begin
        work_nxt = work;
        y_nxt    = 1'b0;
        case (work)
            S0: begin
                case (acc_sym)
                    2'b11:   work_nxt = S0;
                    2'b10:   work_nxt = S2;
                    2'b01:   work_nxt = S1;
                    default: work_nxt = S0;
                endcase
            end
            S1: begin
                case (acc_sym)
                    2'b11:   work_nxt = S1;
                    2'b10:   work_nxt = S3;
                    2'b01:   work_nxt = S0;
                    default: work_nxt = S2;
                endcase
            end
            S2: begin
                y_nxt = (acc_sym == 2'b00);
                case (acc_sym)
                    2'b11:   work_nxt = S2;
                    2'b10:   work_nxt = S1;
                    2'b01:   work_nxt = S0;
                    default: work_nxt = S3;
                endcase
            end
            default: begin
                y_nxt = (acc_sym == 2'b00) || (acc_sym == 2'b10);
                case (acc_sym)
                    2'b11:   work_nxt = S0;
                    2'b10:   work_nxt = S3;
                    2'b01:   work_nxt = S0;
                    default: work_nxt = S1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            rr        <= 1'b0;
            burst_cnt <= 8'd0;
            work      <= S0;
            y_valid_q <= 1'b0;
            y_q       <= 1'b0;
            y_id_q    <= 1'b0;
`ifdef MEALY_CTX_SAVE_EN
            ctx_a     <= S0;
            ctx_b     <= S0;
`endif
        end else begin
            y_valid_q <= acc;
            if (acc) begin
                y_q    <= y_nxt;
                y_id_q <= gnt;
            end
            case (state)
                IDLE: begin
                    if (bus.a_valid || bus.b_valid) begin
                        state     <= GRANT;
                        gnt       <= win;
                        burst_cnt <= 8'd0;
                        work      <= grant_load;
                    end
                end
                default: begin
                    if (acc) begin
                        work      <= work_nxt;
                        burst_cnt <= burst_cnt + 8'd1;
`ifdef MEALY_CTX_SAVE_EN
                        if (gnt) ctx_b <= work_nxt;
                        else     ctx_a <= work_nxt;
`endif
                    end
                    // Releasing hands the next tie to the other requester.
                    if (release_now) begin
                        state <= IDLE;
                        rr    <= ~gnt;
                    end
                end
            endcase
        end
    end

    assign bus.y_valid   = y_valid_q;
    assign bus.y         = y_q;
    assign bus.y_id      = y_id_q;
    assign bus.busy      = (state == GRANT);
    assign bus.dbg_state = state;
    assign bus.dbg_work  = work;

endmodule

// File: tb/tb_mealy_ctx_arbiter.sv
// Directed bench for mealy_ctx_arbiter: packets, ties, burst truncation and mid-grant reset.
// Expected y values are hand-derived from the Mealy table; build with MEALY_CTX_SAVE_EN for the context variant.
module tb_mealy_ctx_arbiter;

    logic clk;
    logic rst_n;
    mealy_ctx_arbiter_if bus ();

    mealy_ctx_arbiter #(.MAX_BURST(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec;
    int          n_err;
    int          acc_cnt;
    int          mon_cnt;
    logic        mon_en;
    logic        exp_v;
    logic [1:0]  ent;
    logic [1:0]  exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: y/y_id must appear exactly one cycle after each acceptance
    always @(negedge clk) begin
        if (mon_en) begin
            exp_v   = (acc_cnt != mon_cnt);
            mon_cnt = acc_cnt;
            check("y_valid", 32'(bus.y_valid), 32'(exp_v));
            if (exp_v && bus.y_valid === 1'b1) begin
                ent = exp_q.pop_front();
                check("y_id", 32'(bus.y_id), 32'(ent[1]));
                check("y", 32'(bus.y), 32'(ent[0]));
            end
        end
    end

    // driver tasks
    task automatic drive(input bit who, input bit v, input logic [1:0] sym, input bit last);
        if (!who) begin
            bus.a_valid = v; bus.a_sym = sym; bus.a_last = last;
        end else begin
            bus.b_valid = v; bus.b_sym = sym; bus.b_last = last;
        end
    endtask

    task automatic arb_cyc();
        @(negedge clk); #1;
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("a_ready_idle", 32'(bus.a_ready), 32'd0);
        check("b_ready_idle", 32'(bus.b_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic put(input bit who, input logic [1:0] sym, input bit last, input bit exp_y);
        drive(who, 1'b1, sym, last);
        @(negedge clk); #1;
        check("busy_grant", 32'(bus.busy), 32'd1);
        check(who ? "b_ready" : "a_ready", 32'(who ? bus.b_ready : bus.a_ready), 32'd1);
        check(who ? "a_ready_held" : "b_ready_held", 32'(who ? bus.a_ready : bus.b_ready), 32'd0);
        exp_q.push_back({who, exp_y});
        acc_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    localparam bit SAVE =
`ifdef MEALY_CTX_SAVE_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin
        n_vec = 0; n_err = 0; acc_cnt = 0; mon_cnt = 0; mon_en = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // reset state
        @(negedge clk); #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_y_id", 32'(bus.y_id), 32'd0);
        check("rst_dbg_state", 32'(bus.dbg_state), 32'd0);
        check("rst_dbg_work", 32'(bus.dbg_work), 32'd0);
        @(posedge clk); #1;

        // A: 01,00,00(last) -> y 0,0,1; busy drops after third
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        arb_cyc();
        put(1'b0, 2'b01, 1'b0, 1'b0);
        put(1'b0, 2'b00, 1'b0, 1'b0);
        put(1'b0, 2'b00, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        arb_cyc();

        // A: 10(last) -> y from saved S3 or from S0
        drive(1'b0, 1'b1, 2'b10, 1'b1);
        arb_cyc();
        put(1'b0, 2'b10, 1'b1, SAVE);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        arb_cyc();

        // tie after reset: A first, B after one idle cycle, next tie back to A
        do_reset();
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        arb_cyc();
        put(1'b0, 2'b01, 1'b0, 1'b0);
        put(1'b0, 2'b00, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 2'b11, 1'b1);
        arb_cyc();
        put(1'b1, 2'b00, 1'b0, 1'b0);
        put(1'b1, 2'b10, 1'b0, 1'b0);
        put(1'b1, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 2'b11, 1'b1);
        arb_cyc();
        put(1'b0, 2'b11, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        arb_cyc();
        put(1'b1, 2'b11, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        arb_cyc();

        // B: ten 11 symbols, last on the 10th -> forced release after 8
        drive(1'b1, 1'b1, 2'b11, 1'b0);
        arb_cyc();
        for (int i = 0; i < 8; i++) put(1'b1, 2'b11, 1'b0, 1'b0);
        arb_cyc();
        put(1'b1, 2'b11, 1'b0, 1'b0);
        put(1'b1, 2'b11, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        arb_cyc();

        // reset mid-grant of A after 2 of 4 symbols (A context reaches S3)
        do_reset();
        drive(1'b0, 1'b1, 2'b10, 1'b0);
        arb_cyc();
        put(1'b0, 2'b10, 1'b0, 1'b0);
        put(1'b0, 2'b00, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 2'b01, 1'b0);
        rst_n = 1'b0;
        @(negedge clk); #1;
        check("a_ready_in_reset", 32'(bus.a_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk); #1;
        check("post_rst_work", 32'(bus.dbg_work), 32'd0);
        @(posedge clk); #1;
        arb_cyc();
        drive(1'b0, 1'b1, 2'b10, 1'b1);
        arb_cyc();
        put(1'b0, 2'b10, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        arb_cyc();
        arb_cyc();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
